axis128_pixel_seq: RTL and testbench

Pixel sequencer for the 128-bit ARGB video stream on the UDP receive path. Accepts AXI-Stream beats carrying four 32-bit ARGB pixels, splits each beat into lanes, and emits one pixel per clock with ready/valid backpressure, x/y position and frame markers. It sits between the UDP payload depacketizer and the face-detection pixel pipeline. It also checks line and frame framing and resynchronises on errors.

---
 rtl/pixseq_pkg.sv | 26 ++
 rtl/u128_to_24_to_888.sv | 25 ++
 rtl/axis128_pixel_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_axis128_pixel_seq.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixseq_pkg.sv
// Shared types and constants for the 128-bit ARGB pixel sequencer.
package pixseq_pkg;

  localparam int PARALLEL_NUM = 4;
  localparam int PIXEL_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESYNC = 2'd2
  } state_t;

  localparam logic [1:0] ERR_EARLY_EOL = 2'b01;
  localparam logic [1:0] ERR_MISS_EOL  = 2'b10;
  localparam logic [1:0] ERR_SOF       = 2'b11;

  typedef logic [1:0] lane_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } argb_t;

endpackage

// File: rtl/u128_to_24_to_888.sv
// Splits a stored beat (four 24-bit RGB lanes, plus alpha when PIXSEQ_ALPHA_EN)
// into per-lane 8-bit component arrays.
module u128_to_24_to_888
  import pixseq_pkg::*;
(
`ifdef PIXSEQ_ALPHA_EN
  input  logic [31:0] alpha_i,
  output logic [7:0]  a_o [PARALLEL_NUM],
`endif
  input  logic [95:0] rgb_i,
  output logic [7:0]  r_o [PARALLEL_NUM],
  output logic [7:0]  g_o [PARALLEL_NUM],
  output logic [7:0]  b_o [PARALLEL_NUM]
);

  for (genvar k = 0; k < PARALLEL_NUM; k++) begin : g_lane
    assign r_o[k] = rgb_i[k*24+16 +: 8];
    assign g_o[k] = rgb_i[k*24+8  +: 8];
    assign b_o[k] = rgb_i[k*24    +: 8];
`ifdef PIXSEQ_ALPHA_EN
    assign a_o[k] = alpha_i[k*8 +: 8];
`endif
  end

endmodule

// File: rtl/axis128_pixel_seq.sv
// 128-bit AXI-Stream ARGB beat to one-pixel-per-clock sequencer with framing checks.
// Define PIXSEQ_ALPHA_EN to carry the alpha byte; otherwise o_pix_a is 8'hFF.
module axis128_pixel_seq
  import pixseq_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [127:0] s_axis_tdata,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic         s_axis_tuser,
  input  logic         s_axis_tlast,
  output logic         o_pix_valid,
  input  logic         i_pix_ready,
  output logic [7:0]   o_pix_a,
  output logic [7:0]   o_pix_r,
  output logic [7:0]   o_pix_g,
  output logic [7:0]   o_pix_b,
  output logic [11:0]  o_pix_x,
  output logic [11:0]  o_pix_y,
  output logic         o_sof,
  output logic         o_eol,
  output logic         o_eof,
  output logic         o_err,
  output logic [1:0]   o_err_code,
  output logic [15:0]  o_frame_cnt
);

  localparam logic [9:0]  LAST_BX = 10'(H_ACTIVE / 4 - 1);
  localparam logic [11:0] LAST_Y  = 12'(V_ACTIVE - 1);

  state_t      state_q;
  logic        run_q;
  logic        beat_full_q;
  lane_t       lane_q;
  logic [95:0] beat_rgb_q;
  logic [95:0] beat_rgb_d;
`ifdef PIXSEQ_ALPHA_EN
  logic [31:0] beat_a_q;
  logic [31:0] beat_a_d;
`else
  logic        alpha_unused;
`endif
  logic [9:0]  pbx_q;
  logic [11:0] pby_q;
  logic        psof_q;
  logic        peol_q;
  logic        peof_q;
  logic [9:0]  bx_q;
  logic [11:0] by_q;
  logic        err_q;
  logic [1:0]  err_code_q;
  logic [15:0] frame_cnt_q;

  logic        pix_hs;
  logic        last_lane;
  logic        eof_hs;
  logic        beat_acc;
  logic        beat_take;
  logic        at_origin;
  logic        err_early;
  logic        err_miss;
  logic        err_sof;
  logic [9:0]  ex;
  logic [11:0] ey;

  logic [7:0]  r_lane [PARALLEL_NUM];
  logic [7:0]  g_lane [PARALLEL_NUM];
  logic [7:0]  b_lane [PARALLEL_NUM];
`ifdef PIXSEQ_ALPHA_EN
  logic [7:0]  a_lane [PARALLEL_NUM];
`endif
  argb_t       pix;

  assign pix_hs        = beat_full_q && i_pix_ready;
  assign last_lane     = (lane_q == 2'd3);
  assign eof_hs        = pix_hs && last_lane && peof_q;
  assign s_axis_tready = run_q && (!beat_full_q || (last_lane && pix_hs));
  assign beat_acc      = s_axis_tvalid && s_axis_tready;

  // Only the RGB bytes of each lane are stored; alpha has its own register when enabled.
  always_comb begin
    beat_rgb_d = '0;
    for (int k = 0; k < PARALLEL_NUM; k++) begin
      beat_rgb_d[k*24 +: 24] = s_axis_tdata[k*PIXEL_WIDTH +: 24];
    end
  end

`ifdef PIXSEQ_ALPHA_EN
  always_comb begin
    beat_a_d = '0;
    for (int k = 0; k < PARALLEL_NUM; k++) begin
      beat_a_d[k*8 +: 8] = s_axis_tdata[k*PIXEL_WIDTH+24 +: 8];
    end
  end
`else
  assign alpha_unused = ^{s_axis_tdata[127:120], s_axis_tdata[95:88],
                          s_axis_tdata[63:56], s_axis_tdata[31:24]};
`endif

  // A tuser beat always restarts at (0,0); a plain beat at (0,0) in ACTIVE means the
  // previous frame ended and we are waiting for the next start, so it is dropped.
  always_comb begin
    ex        = s_axis_tuser ? 10'd0 : bx_q;
    ey        = s_axis_tuser ? 12'd0 : by_q;
    at_origin = (bx_q == 10'd0) && (by_q == 12'd0);
    beat_take = s_axis_tuser || ((state_q == ACTIVE) && !at_origin);
    err_early = s_axis_tlast && (ex != LAST_BX);
    err_miss  = !s_axis_tlast && (ex == LAST_BX);
    err_sof   = (state_q == ACTIVE) && s_axis_tuser && !at_origin;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      run_q       <= 1'b0;
      beat_full_q <= 1'b0;
      lane_q      <= '0;
      beat_rgb_q  <= '0;
`ifdef PIXSEQ_ALPHA_EN
      beat_a_q    <= '0;
`endif
      pbx_q       <= '0;
      pby_q       <= '0;
      psof_q      <= 1'b0;
      peol_q      <= 1'b0;
      peof_q      <= 1'b0;
      bx_q        <= '0;
      by_q        <= '0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      run_q <= 1'b1;
      err_q <= 1'b0;
      if (pix_hs) begin
        lane_q <= lane_q + 2'd1;
        if (last_lane) begin
          beat_full_q <= 1'b0;
        end
      end
      if (eof_hs) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        if (state_q == ACTIVE) begin
          state_q <= IDLE;
        end
      end
      // A load in the same cycle overrides the emptying and the eof return to IDLE.
      if (beat_acc && beat_take) begin
        if (err_early || err_miss) begin
          err_q      <= 1'b1;
          err_code_q <= err_early ? ERR_EARLY_EOL : ERR_MISS_EOL;
          state_q    <= RESYNC;
        end else begin
          if (err_sof) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_SOF;
          end
          state_q     <= ACTIVE;
          beat_full_q <= 1'b1;
          lane_q      <= '0;
          beat_rgb_q  <= beat_rgb_d;
`ifdef PIXSEQ_ALPHA_EN
          beat_a_q    <= beat_a_d;
`endif
          pbx_q       <= ex;
          pby_q       <= ey;
          psof_q      <= s_axis_tuser;
          peol_q      <= s_axis_tlast;
          peof_q      <= s_axis_tlast && (ey == LAST_Y);
          if (s_axis_tlast) begin
            bx_q <= 10'd0;
            by_q <= (ey == LAST_Y) ? 12'd0 : ey + 12'd1;
          end else begin
            bx_q <= ex + 10'd1;
            by_q <= ey;
          end
        end
      end
    end
  end

  u128_to_24_to_888 u_split (
`ifdef PIXSEQ_ALPHA_EN
    .alpha_i (beat_a_q),
    .a_o     (a_lane),
`endif
    .rgb_i   (beat_rgb_q),
    .r_o     (r_lane),
    .g_o     (g_lane),
    .b_o     (b_lane)
  );

  always_comb begin
`ifdef PIXSEQ_ALPHA_EN
    pix.a = a_lane[lane_q];
`else
    pix.a = 8'hFF;
`endif
    pix.r = r_lane[lane_q];
    pix.g = g_lane[lane_q];
    pix.b = b_lane[lane_q];
  end

  assign o_pix_valid = beat_full_q;
  assign o_pix_a     = pix.a;
  assign o_pix_r     = pix.r;
  assign o_pix_g     = pix.g;
  assign o_pix_b     = pix.b;
  assign o_pix_x     = {pbx_q, lane_q};
  assign o_pix_y     = pby_q;
  assign o_sof       = beat_full_q && psof_q && (lane_q == 2'd0);
  assign o_eol       = beat_full_q && peol_q && last_lane;
  assign o_eof       = beat_full_q && peof_q && last_lane;
  assign o_err       = err_q;
  assign o_err_code  = err_code_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_axis128_pixel_seq.sv
// Directed bench for axis128_pixel_seq with an 8x2 frame geometry.
module tb_axis128_pixel_seq;

  localparam int H = 8;
  localparam int V = 2;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    logic        eol;
    logic        eof;
  } rec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] tdata;
  logic         tvalid, tready, tuser, tlast;
  logic         pv, pr;
  logic [7:0]   pa, prr, pg, pb;
  logic [11:0]  px, py;
  logic         sof, eol, eof, err;
  logic [1:0]   ecode;
  logic [15:0]  fcnt;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdy_mode = 0;
  int acc_cyc  = 0;
  int err_cnt  = 0;
  int err_cyc  = -1;
  int stall_bad = 0;
  int trdy_bad  = 0;
  rec_t pq[$];
  int   pcyc[$];
  rec_t eq[$];

  axis128_pixel_seq #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tuser  (tuser),
    .s_axis_tlast  (tlast),
    .o_pix_valid   (pv),
    .i_pix_ready   (pr),
    .o_pix_a       (pa),
    .o_pix_r       (prr),
    .o_pix_g       (pg),
    .o_pix_b       (pb),
    .o_pix_x       (px),
    .o_pix_y       (py),
    .o_sof         (sof),
    .o_eol         (eol),
    .o_eof         (eof),
    .o_err         (err),
    .o_err_code    (ecode),
    .o_frame_cnt   (fcnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    pr = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pr = (rdy_mode == 1) ? ~pr : 1'b1;
    end
  end

  // Observer: records handshaken pixels, error pulses and stall/ready behaviour.
  initial begin : mon
    rec_t cur, prev;
    logic prev_stall;
    prev = '0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      cur = {pa, prr, pg, pb, px, py, sof, eol, eof};
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!pv || cur !== prev)) stall_bad++;
        if (pv && px[1:0] != 2'd3 && tready) trdy_bad++;
        if (pv && px[1:0] == 2'd3 && pr && !tready) trdy_bad++;
        if (pv && pr) begin
          pq.push_back(cur);
          pcyc.push_back(cyc);
        end
        if (err) begin
          err_cnt++;
          err_cyc = cyc;
        end
        prev = cur;
        prev_stall = pv && !pr;
      end
    end
  end

  function automatic logic [127:0] beat(input logic [7:0] tag, input int bid);
    logic [127:0] d;
    for (int k = 0; k < 4; k++) d[k*32 +: 32] = {4'hC, 2'(bid), 2'(k), tag, 8'(bid), 8'(k)};
    return d;
  endfunction

  task automatic add_beat(input logic [7:0] tag, input int bid, input int bx, input int y,
                          input logic bsof, input logic beol, input logic beof);
    rec_t e;
    for (int k = 0; k < 4; k++) begin
`ifdef PIXSEQ_ALPHA_EN
      e.a = {4'hC, 2'(bid), 2'(k)};
`else
      e.a = 8'hFF;
`endif
      e.r = tag;
      e.g = 8'(bid);
      e.b = 8'(k);
      e.x = 12'(bx * 4 + k);
      e.y = 12'(y);
      e.sof = bsof && (k == 0);
      e.eol = beol && (k == 3);
      e.eof = beof && (k == 3);
      eq.push_back(e);
    end
  endtask

  task automatic add_frame(input logic [7:0] tag);
    for (int b = 0; b < 4; b++) add_beat(tag, b, b % 2, b / 2, b == 0, (b % 2) == 1, b == 3);
  endtask

  task automatic send_beat(input logic [127:0] d, input logic u, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    tdata = d; tuser = u; tlast = l; tvalid = 1'b1;
    while (!tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_assert++; n_fail++;
      $display("FAIL beat_accept_timeout tready=%0b required 1", tready);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] tag, output int first_acc);
    first_acc = 0;
    for (int b = 0; b < 4; b++) begin
      send_beat(beat(tag, b), b == 0, (b % 2) == 1);
      if (b == 0) first_acc = acc_cyc;
    end
  endtask

  task automatic wait_pix(input int n);
    int t;
    t = 0;
    while (pq.size() < n && t < 400) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (pq.size() < n) begin
      n_assert++; n_fail++;
      $display("FAIL pixel_timeout got %0d pixels required %0d", pq.size(), n);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_q();
    pq.delete(); pcyc.delete(); eq.delete();
  endtask

  task automatic test_reset();
    logic [7:0] a_rst;
`ifdef PIXSEQ_ALPHA_EN
    a_rst = 8'h00;
`else
    a_rst = 8'hFF;
`endif
    #2;
    n_assert++;
    if ({tready, pv, sof, eol, eof, err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b required 000000", {tready, pv, sof, eol, eof, err});
    end
    n_assert++;
    if ({px, py, prr, pg, pb, pa} !== {48'h0, a_rst}) begin
      n_fail++; $display("FAIL reset_data got %h required %h", {px, py, prr, pg, pb, pa}, {48'h0, a_rst});
    end
    n_assert++;
    if ({ecode, fcnt} !== 18'h0) begin
      n_fail++; $display("FAIL reset_cnt got %h required 0", {ecode, fcnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_assert++;
    if (tready !== 1'b0) begin n_fail++; $display("FAIL tready_before_clk got %b required 0", tready); end
    @(negedge clk);
    #1;
    n_assert++;
    if (tready !== 1'b1) begin n_fail++; $display("FAIL tready_after_clk got %b required 1", tready); end
  endtask

  task automatic test_clean_frame();
    int fa;
    rec_t got;
    rdy_mode = 0;
    clear_q();
    add_frame(8'h11);
    send_frame(8'h11, fa);
    wait_pix(16);
    for (int i = 0; i < 16; i++) begin
      got = (i < pq.size()) ? pq[i] : '1;
      n_assert++;
      if (got !== eq[i]) begin n_fail++; $display("FAIL clean_pix[%0d] got %h required %h", i, got, eq[i]); end
    end
    n_assert++;
    if (pcyc.size() < 16 || pcyc[0] != fa) begin
      n_fail++; $display("FAIL clean_latency got %0d required %0d", pcyc.size() > 0 ? pcyc[0] : -1, fa);
    end
    n_assert++;
    if (pcyc.size() < 16 || pcyc[15] - pcyc[0] != 15) begin
      n_fail++; $display("FAIL clean_back_to_back got span %0d required 15", pcyc.size() >= 16 ? pcyc[15] - pcyc[0] : -1);
    end
    idle_cycles(2);
    n_assert++;
    if (fcnt !== 16'd1) begin n_fail++; $display("FAIL clean_frame_cnt got %0d required 1", fcnt); end
  endtask

  task automatic test_stall();
    int fa, s0, t0;
    rec_t got;
    s0 = stall_bad; t0 = trdy_bad;
    rdy_mode = 1;
    clear_q();
    add_frame(8'h22);
    send_frame(8'h22, fa);
    wait_pix(16);
    rdy_mode = 0;
    for (int i = 0; i < 16; i++) begin
      got = (i < pq.size()) ? pq[i] : '1;
      n_assert++;
      if (got !== eq[i]) begin n_fail++; $display("FAIL stall_pix[%0d] got %h required %h", i, got, eq[i]); end
    end
    n_assert++;
    if (stall_bad != s0) begin n_fail++; $display("FAIL stall_hold got %0d changes required 0", stall_bad - s0); end
    n_assert++;
    if (trdy_bad != t0) begin n_fail++; $display("FAIL stall_tready got %0d bad cycles required 0", trdy_bad - t0); end
    idle_cycles(3);
    n_assert++;
    if (fcnt !== 16'd2) begin n_fail++; $display("FAIL stall_frame_cnt got %0d required 2", fcnt); end
  endtask

  task automatic test_early_eol();
    int e0, fa;
    rec_t got;
    clear_q();
    e0 = err_cnt;
    send_beat(beat(8'h33, 0), 1'b1, 1'b1);
    idle_cycles(3);
    n_assert++;
    if (err_cnt - e0 != 1 || ecode !== 2'b01) begin
      n_fail++; $display("FAIL early_eol_err got %0d pulses code %b required 1 pulse code 01", err_cnt - e0, ecode);
    end
    n_assert++;
    if (err_cyc != acc_cyc) begin n_fail++; $display("FAIL early_eol_timing got %0d required %0d", err_cyc, acc_cyc); end
    send_beat(beat(8'h33, 1), 1'b0, 1'b0);
    idle_cycles(6);
    n_assert++;
    if (pq.size() != 0 || err_cnt - e0 != 1) begin
      n_fail++; $display("FAIL resync_drop got %0d pixels %0d errors required 0 pixels 1 error", pq.size(), err_cnt - e0);
    end
    add_frame(8'h44);
    send_frame(8'h44, fa);
    wait_pix(16);
    for (int i = 0; i < 16; i++) begin
      got = (i < pq.size()) ? pq[i] : '1;
      n_assert++;
      if (got !== eq[i]) begin n_fail++; $display("FAIL resync_pix[%0d] got %h required %h", i, got, eq[i]); end
    end
    idle_cycles(2);
    n_assert++;
    if (fcnt !== 16'd3) begin n_fail++; $display("FAIL resync_frame_cnt got %0d required 3", fcnt); end
  endtask

  task automatic test_miss_eol();
    int e0;
    rec_t got;
    clear_q();
    e0 = err_cnt;
    add_beat(8'h55, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    send_beat(beat(8'h55, 0), 1'b1, 1'b0);
    send_beat(beat(8'h55, 1), 1'b0, 1'b0);
    idle_cycles(6);
    n_assert++;
    if (err_cnt - e0 != 1 || ecode !== 2'b10) begin
      n_fail++; $display("FAIL miss_eol_err got %0d pulses code %b required 1 pulse code 10", err_cnt - e0, ecode);
    end
    n_assert++;
    if (err_cyc != acc_cyc) begin n_fail++; $display("FAIL miss_eol_timing got %0d required %0d", err_cyc, acc_cyc); end
    n_assert++;
    if (pq.size() != 4) begin n_fail++; $display("FAIL miss_eol_count got %0d pixels required 4", pq.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < pq.size()) ? pq[i] : '1;
      n_assert++;
      if (got !== eq[i]) begin n_fail++; $display("FAIL miss_eol_pix[%0d] got %h required %h", i, got, eq[i]); end
    end
    n_assert++;
    if (fcnt !== 16'd3) begin n_fail++; $display("FAIL miss_eol_frame_cnt got %0d required 3", fcnt); end
  endtask

  task automatic test_tuser_mid();
    int e0;
    rec_t got;
    clear_q();
    e0 = err_cnt;
    add_beat(8'h66, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    add_beat(8'h66, 1, 1, 0, 1'b0, 1'b1, 1'b0);
    add_beat(8'h66, 2, 0, 0, 1'b1, 1'b0, 1'b0);
    add_beat(8'h66, 3, 1, 0, 1'b0, 1'b1, 1'b0);
    add_beat(8'h66, 4, 0, 1, 1'b0, 1'b0, 1'b0);
    add_beat(8'h66, 5, 1, 1, 1'b0, 1'b1, 1'b1);
    send_beat(beat(8'h66, 0), 1'b1, 1'b0);
    send_beat(beat(8'h66, 1), 1'b0, 1'b1);
    send_beat(beat(8'h66, 2), 1'b1, 1'b0);
    send_beat(beat(8'h66, 3), 1'b0, 1'b1);
    wait_pix(16);
    idle_cycles(2);
    n_assert++;
    if (err_cnt - e0 != 1 || ecode !== 2'b11) begin
      n_fail++; $display("FAIL tuser_mid_err got %0d pulses code %b required 1 pulse code 11", err_cnt - e0, ecode);
    end
    n_assert++;
    if (fcnt !== 16'd3) begin n_fail++; $display("FAIL tuser_mid_cnt_hold got %0d required 3", fcnt); end
    send_beat(beat(8'h66, 4), 1'b0, 1'b0);
    send_beat(beat(8'h66, 5), 1'b0, 1'b1);
    wait_pix(24);
    for (int i = 0; i < 24; i++) begin
      got = (i < pq.size()) ? pq[i] : '1;
      n_assert++;
      if (got !== eq[i]) begin n_fail++; $display("FAIL tuser_mid_pix[%0d] got %h required %h", i, got, eq[i]); end
    end
    idle_cycles(2);
    n_assert++;
    if (fcnt !== 16'd4) begin n_fail++; $display("FAIL tuser_mid_frame_cnt got %0d required 4", fcnt); end
  endtask

  task automatic test_reset_mid();
    int fa;
    rec_t got;
    clear_q();
    send_beat(beat(8'h77, 0), 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({tready, pv, sof, err} !== 4'b0) begin
      n_fail++; $display("FAIL mid_reset_ctrl got %b required 0000", {tready, pv, sof, err});
    end
    n_assert++;
    if ({px, py, prr, pg, pb, ecode, fcnt} !== 66'h0) begin
      n_fail++; $display("FAIL mid_reset_data got %h required 0", {px, py, prr, pg, pb, ecode, fcnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    send_beat(beat(8'h77, 1), 1'b0, 1'b0);
    idle_cycles(6);
    n_assert++;
    if (pq.size() != 0) begin n_fail++; $display("FAIL post_reset_drop got %0d pixels required 0", pq.size()); end
    add_frame(8'h88);
    send_frame(8'h88, fa);
    wait_pix(16);
    for (int i = 0; i < 16; i++) begin
      got = (i < pq.size()) ? pq[i] : '1;
      n_assert++;
      if (got !== eq[i]) begin n_fail++; $display("FAIL post_reset_pix[%0d] got %h required %h", i, got, eq[i]); end
    end
    idle_cycles(2);
    n_assert++;
    if (fcnt !== 16'd1) begin n_fail++; $display("FAIL post_reset_frame_cnt got %0d required 1", fcnt); end
  endtask

  initial begin
    tdata = '0; tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0;
    test_reset();
    test_clean_frame();
    test_stall();
    test_early_eol();
    test_miss_eol();
    test_tuser_mid();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
